// File: rtl/bus_pkg.sv
// Shared bus definitions: field widths, master transmit FSM states, burst-word layout.
package bus_pkg;
   localparam int ADDR_W  = 12;
   localparam int DATA_W  = 8;
   localparam int BURST_W = 13;

   typedef enum logic [2:0] {IDLE, REQ, SHIFT, LOAD, BREQ, BSHIFT, DONE} mop_state_e;

   // Burst word: bit 0 enables the burst, the upper bits count extra beats.
   typedef struct packed {
      logic [BURST_W-2:0] cnt;
      logic               en;
   } burst_t;

   function automatic logic [BURST_W-2:0] burst_beats(input burst_t b);
      return b.en ? b.cnt : '0;
   endfunction
endpackage

// File: rtl/piso_shifter.sv
// LSB-first parallel-in/serial-out shifter with a registered serial output and a done flag.
// Define MASTER_OUT_PARITY_EN to append an even-parity bit after the field.
module piso_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] din_i,
   output logic             sout_o,
   output logic             last_o
);
`ifdef MASTER_OUT_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int CW = $clog2(NBITS + 1);

   logic [NBITS-1:0] sr_q;
   logic [CW-1:0]    cnt_q;
   logic             sout_q;

   // Loading clears the output so the cycle after the handshake is idle on the line;
   // once the field is exhausted zeros shift out and the line returns to 0.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sr_q   <= '0;
         cnt_q  <= '0;
         sout_q <= 1'b0;
      end else if (load_i) begin
`ifdef MASTER_OUT_PARITY_EN
         sr_q   <= {^din_i, din_i};
`else
         sr_q   <= din_i;
`endif
         cnt_q  <= '0;
         sout_q <= 1'b0;
      end else if (shift_i) begin
         sout_q <= sr_q[0];
         sr_q   <= sr_q >> 1;
         if (cnt_q != CW'(NBITS)) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign sout_o = sout_q;
   assign last_o = (cnt_q == CW'(NBITS));
endmodule

// File: rtl/master_out_port.sv
// master_out_port: master-side serial transmit port (address + write data, LSB first, bursts).
// Define MASTER_OUT_PARITY_EN to append an even-parity bit to each serial field.
module master_out_port #(
   parameter int ADDR_W  = bus_pkg::ADDR_W,
   parameter int DATA_W  = bus_pkg::DATA_W,
   parameter int BURST_W = bus_pkg::BURST_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               wr,
   input  logic [ADDR_W-1:0]  addr_in,
   input  logic [DATA_W-1:0]  data_in,
   input  logic [BURST_W-1:0] burst_in,
   input  logic               slave_ready,
   output logic               master_valid,
   output logic               tx_addr,
   output logic               tx_data,
   output logic               write_en,
   output logic               read_en,
   output logic [BURST_W-1:0] burst,
   output logic               data_req,
   output logic               busy,
   output logic               tx_done
);
   import bus_pkg::*;

   mop_state_e         state_q;
   logic               wr_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  data_q;
   logic [BURST_W-1:0] burst_q;
   logic [BURST_W-2:0] beats_q;
   logic               master_valid_q, write_en_q, read_en_q;
   logic               data_req_q, busy_q, tx_done_q;
   logic               hs, shift_en, addr_load, data_load, addr_last, data_last;
   logic [DATA_W-1:0]  data_ld;

   assign hs        = master_valid_q & slave_ready;
   assign shift_en  = (state_q == SHIFT) || (state_q == BSHIFT);
   assign addr_load = hs && (state_q == REQ);
   assign data_load = hs && ((state_q == REQ) || (state_q == BREQ));
   // Reads send an all-zero data field so tx_data stays low.
   assign data_ld   = wr_q ? data_q : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         wr_q           <= 1'b0;
         addr_q         <= '0;
         data_q         <= '0;
         burst_q        <= '0;
         beats_q        <= '0;
         master_valid_q <= 1'b0;
         write_en_q     <= 1'b0;
         read_en_q      <= 1'b0;
         data_req_q     <= 1'b0;
         busy_q         <= 1'b0;
         tx_done_q      <= 1'b0;
      end else begin
         data_req_q <= 1'b0;
         tx_done_q  <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               wr_q           <= wr;
               addr_q         <= addr_in;
               data_q         <= data_in;
               burst_q        <= burst_in;
               beats_q        <= burst_beats(burst_t'(burst_in));
               write_en_q     <= wr;
               read_en_q      <= ~wr;
               busy_q         <= 1'b1;
               master_valid_q <= 1'b1;
               state_q        <= REQ;
            end
            REQ: if (hs) begin
               master_valid_q <= 1'b0;
               state_q        <= SHIFT;
            end
            SHIFT: if (addr_last) begin
               if (wr_q && (beats_q != '0)) begin
                  data_req_q <= 1'b1;
                  state_q    <= LOAD;
               end else begin
                  tx_done_q  <= 1'b1;
                  state_q    <= DONE;
               end
            end
            LOAD: begin
               data_q         <= data_in;
               master_valid_q <= 1'b1;
               state_q        <= BREQ;
            end
            BREQ: if (hs) begin
               master_valid_q <= 1'b0;
               if (beats_q != '0) beats_q <= beats_q - 1'b1;
               state_q        <= BSHIFT;
            end
            BSHIFT: if (data_last) begin
               if (beats_q != '0) begin
                  data_req_q <= 1'b1;
                  state_q    <= LOAD;
               end else begin
                  tx_done_q  <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               busy_q     <= 1'b0;
               write_en_q <= 1'b0;
               read_en_q  <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   piso_shifter #(.WIDTH(ADDR_W)) u_addr_sh (
      .clk_i   (clk),
      .reset_i (reset),
      .load_i  (addr_load),
      .shift_i (shift_en),
      .din_i   (addr_q),
      .sout_o  (tx_addr),
      .last_o  (addr_last)
   );

   piso_shifter #(.WIDTH(DATA_W)) u_data_sh (
      .clk_i   (clk),
      .reset_i (reset),
      .load_i  (data_load),
      .shift_i (shift_en),
      .din_i   (data_ld),
      .sout_o  (tx_data),
      .last_o  (data_last)
   );

   assign master_valid = master_valid_q;
   assign write_en     = write_en_q;
   assign read_en      = read_en_q;
   assign burst        = burst_q;
   assign data_req     = data_req_q;
   assign busy         = busy_q;
   assign tx_done      = tx_done_q;
endmodule
